// File: rtl/fsm_stages_pkg.sv
// rtl/fsm_stages_pkg.sv - stage encoding shared by fsm_ctrl, its interface and monitors
package fsm_stages_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ONE  = 2'b01,
    S_TWO  = 2'b10,
    S_DONE = 2'b11
  } c_state;

endpackage

// File: rtl/fsm_ctrl_if.sv
// rtl/fsm_ctrl_if.sv - qualifier/stage bundle for fsm_ctrl (done_cnt under FSM_CTRL_DONE_CNT_EN)
interface fsm_ctrl_if
`ifdef FSM_CTRL_DONE_CNT_EN
  #(parameter int DONE_CNT_W = 8)
`endif
  ;

  logic                   q1;
  logic                   q2;
  logic [1:0]             count;
  fsm_stages_pkg::c_state state;
`ifdef FSM_CTRL_DONE_CNT_EN
  logic [DONE_CNT_W-1:0]  done_cnt;
`endif

  // Side that drives the qualifiers and observes the stage
  modport master (
    output q1,
    output q2,
`ifdef FSM_CTRL_DONE_CNT_EN
    input  done_cnt,
`endif
    input  count,
    input  state
  );

  // The detector itself
  modport slave (
    input  q1,
    input  q2,
`ifdef FSM_CTRL_DONE_CNT_EN
    output done_cnt,
`endif
    output count,
    output state
  );

endinterface

// File: rtl/fsm_ctrl.sv
// rtl/fsm_ctrl.sv - Moore 4-stage sequence detector on {q1,q2}; optional done counter via FSM_CTRL_DONE_CNT_EN
module fsm_ctrl
  import fsm_stages_pkg::*;
#(
  parameter int HOLD_ON_IDLE = 1,
  parameter int DONE_CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  fsm_ctrl_if.slave  bus
);

  c_state     state_q;
  c_state     state_d;
  logic [1:0] in_w;

  if (DONE_CNT_W < 1) begin : g_bad_done_cnt_w
    $error("fsm_ctrl: DONE_CNT_W must be at least 1");
  end

  assign in_w = {bus.q1, bus.q2};

  // State register; reset aborts any partial sequence immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: 00 holds or drops to idle, 01 always restarts at S_ONE, else advance or abort
  always_comb begin
    state_d = S_IDLE;
    if (in_w == 2'b00) begin
      state_d = (HOLD_ON_IDLE != 0) ? state_q : S_IDLE;
    end else if (in_w == 2'b01) begin
      state_d = S_ONE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ONE:   state_d = (in_w == 2'b10) ? S_TWO : S_IDLE;
        S_TWO:   state_d = (in_w == 2'b11) ? S_DONE : S_IDLE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.state = state_q;
  assign bus.count = state_q;

`ifdef FSM_CTRL_DONE_CNT_EN
  logic [DONE_CNT_W-1:0] done_cnt_q;
  logic [DONE_CNT_W-1:0] done_cnt_d;

  // Count fresh entries into S_DONE only; holding there does not re-count; saturate at all-ones
  always_comb begin
    done_cnt_d = done_cnt_q;
    if ((state_d == S_DONE) && (state_q != S_DONE) && (done_cnt_q != {DONE_CNT_W{1'b1}})) begin
      done_cnt_d = done_cnt_q + 1'b1;
    end
  end

  // Done counter register, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.done_cnt = done_cnt_q;
`endif

endmodule

// File: tb/tb_fsm_ctrl.sv
// tb/tb_fsm_ctrl.sv - table-driven bench for fsm_ctrl with HOLD_ON_IDLE=1 and =0 instances
module tb_fsm_ctrl;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  fsm_ctrl_if u_if_h ();
  fsm_ctrl_if u_if_z ();

  fsm_ctrl #(.HOLD_ON_IDLE(1), .DONE_CNT_W(8)) u_dut_h (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if_h.slave)
  );

  fsm_ctrl #(.HOLD_ON_IDLE(0), .DONE_CNT_W(8)) u_dut_z (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if_z.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] in;
    logic [1:0] exp_h;
    logic [1:0] exp_z;
    int         done_h;
    int         done_z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] in);
    @(negedge clk);
    u_if_h.q1 = in[1];
    u_if_h.q2 = in[0];
    u_if_z.q1 = in[1];
    u_if_z.q2 = in[0];
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic [1:0] eh, input logic [1:0] ez);
    check({tag, " count_h"}, 32'(u_if_h.count), 32'(eh));
    check({tag, " state_h"}, 32'(u_if_h.state), 32'(eh));
    check({tag, " count_z"}, 32'(u_if_z.count), 32'(ez));
    check({tag, " state_z"}, 32'(u_if_z.state), 32'(ez));
  endtask

  task automatic add(input logic [1:0] in, input logic [1:0] eh, input logic [1:0] ez,
                     input int dh, input int dz);
    vec_t v;
    v.in = in; v.exp_h = eh; v.exp_z = ez; v.done_h = dh; v.done_z = dz;
    vecs.push_back(v);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    u_if_h.q1 = 1'b0; u_if_h.q2 = 1'b0;
    u_if_z.q1 = 1'b0; u_if_z.q2 = 1'b0;

    //   in     hold=1 hold=0 done_h done_z
    add(2'b01, 2'd1, 2'd1, 0, 0);
    add(2'b10, 2'd2, 2'd2, 0, 0);
    add(2'b11, 2'd3, 2'd3, 1, 1);
    add(2'b10, 2'd0, 2'd0, 1, 1);
    add(2'b01, 2'd1, 2'd1, 1, 1);
    add(2'b10, 2'd2, 2'd2, 1, 1);
    add(2'b00, 2'd2, 2'd0, 1, 1);
    add(2'b00, 2'd2, 2'd0, 1, 1);
    add(2'b00, 2'd2, 2'd0, 1, 1);
    add(2'b11, 2'd3, 2'd0, 2, 1);
    add(2'b00, 2'd3, 2'd0, 2, 1);
    add(2'b01, 2'd1, 2'd1, 2, 1);
    add(2'b10, 2'd2, 2'd2, 2, 1);
    add(2'b01, 2'd1, 2'd1, 2, 1);
    add(2'b10, 2'd2, 2'd2, 2, 1);
    add(2'b11, 2'd3, 2'd3, 3, 2);
    add(2'b10, 2'd0, 2'd0, 3, 2);
    add(2'b10, 2'd0, 2'd0, 3, 2);
    add(2'b01, 2'd1, 2'd1, 3, 2);
    add(2'b11, 2'd0, 2'd0, 3, 2);
    add(2'b00, 2'd0, 2'd0, 3, 2);
    add(2'b01, 2'd1, 2'd1, 3, 2);
    add(2'b11, 2'd0, 2'd0, 3, 2);
    add(2'b01, 2'd1, 2'd1, 3, 2);
    add(2'b01, 2'd1, 2'd1, 3, 2);
    add(2'b10, 2'd2, 2'd2, 3, 2);
    add(2'b10, 2'd0, 2'd0, 3, 2);
    add(2'b01, 2'd1, 2'd1, 3, 2);
    add(2'b10, 2'd2, 2'd2, 3, 2);
    add(2'b11, 2'd3, 2'd3, 4, 3);
    add(2'b11, 2'd0, 2'd0, 4, 3);
    add(2'b01, 2'd1, 2'd1, 4, 3);
    add(2'b10, 2'd2, 2'd2, 4, 3);
    add(2'b11, 2'd3, 2'd3, 5, 4);
    add(2'b01, 2'd1, 2'd1, 5, 4);

    // Reset state, including across a clock edge with non-idle inputs
    #12;
    check_both("reset", 2'd0, 2'd0);
    u_if_h.q1 = 1'b0; u_if_h.q2 = 1'b1;
    u_if_z.q1 = 1'b0; u_if_z.q2 = 1'b1;
    @(posedge clk); #1;
    check_both("reset_held", 2'd0, 2'd0);
`ifdef FSM_CTRL_DONE_CNT_EN
    check("reset done_h", 32'(u_if_h.done_cnt), 32'd0);
`endif
    @(negedge clk);
    u_if_h.q1 = 1'b0; u_if_h.q2 = 1'b0;
    u_if_z.q1 = 1'b0; u_if_z.q2 = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      check_both($sformatf("vec%0d", i), vecs[i].exp_h, vecs[i].exp_z);
`ifdef FSM_CTRL_DONE_CNT_EN
      check($sformatf("vec%0d done_h", i), 32'(u_if_h.done_cnt), 32'(vecs[i].done_h));
      check($sformatf("vec%0d done_z", i), 32'(u_if_z.done_cnt), 32'(vecs[i].done_z));
`endif
    end

    // Asynchronous reset mid-cycle while in S_TWO
    drive(2'b01);
    drive(2'b10);
    check_both("pre_async", 2'd2, 2'd2);
    #2;
    reset = 1'b0;
    #1;
    check_both("async_reset", 2'd0, 2'd0);
`ifdef FSM_CTRL_DONE_CNT_EN
    check("async done_h", 32'(u_if_h.done_cnt), 32'd0);
    check("async done_z", 32'(u_if_z.done_cnt), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Fresh sequence after release, then abort from S_DONE
    drive(2'b01); check_both("post_rst 01", 2'd1, 2'd1);
    drive(2'b10); check_both("post_rst 10", 2'd2, 2'd2);
    drive(2'b11); check_both("post_rst 11", 2'd3, 2'd3);
    drive(2'b10); check_both("post_rst abort", 2'd0, 2'd0);

`ifdef FSM_CTRL_DONE_CNT_EN
    check("post_rst done_h", 32'(u_if_h.done_cnt), 32'd1);
    // Saturation: 300 more detections on an 8-bit counter
    for (int k = 0; k < 300; k++) begin
      drive(2'b01);
      drive(2'b10);
      drive(2'b11);
    end
    check("sat done_h", 32'(u_if_h.done_cnt), 32'd255);
    check("sat done_z", 32'(u_if_z.done_cnt), 32'd255);
    check_both("sat state", 2'd3, 2'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
